// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data requester. One access at a time, round-robin on ties, with a
// per-access timeout that aborts an access the memory never acknowledges.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_req, i_addr             fetch request / byte address
//   i_ack, i_err, i_rdata     fetch done / aborted pulse, fetched word
//   d_req, d_we, d_addr,
//   d_wdata, d_wstrb          data request and command
//   d_ack, d_err, d_rdata     data done / aborted pulse, load data
//   m_req, m_we, m_addr,
//   m_wdata, m_wstrb          shared memory command (registered)
//   m_ack, m_rdata            memory completion pulse and read data
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_n;
    logic               gnt, gnt_n;
    logic               last_d, last_d_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               m_req_n, m_we_n;
    logic [DATA_W-1:0]  m_addr_n, m_wdata_n;
    logic [STRB_W-1:0]  m_wstrb_n;
    logic               i_ack_n, i_err_n, d_ack_n, d_err_n;
    logic [DATA_W-1:0]  i_rdata_n, d_rdata_n;
    logic               sel_d;
    logic               done;
    logic               rsp_ok;
    logic [DATA_W-1:0]  rsp_data;

    // Next-state, grant and registered-output computation
    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        last_d_n  = last_d;
        cnt_n     = cnt;
        m_req_n   = m_req;
        m_we_n    = m_we;
        m_addr_n  = m_addr;
        m_wdata_n = m_wdata;
        m_wstrb_n = m_wstrb;
        i_ack_n   = 1'b0;
        i_err_n   = 1'b0;
        d_ack_n   = 1'b0;
        d_err_n   = 1'b0;
        i_rdata_n = i_rdata;
        d_rdata_n = d_rdata;
        sel_d     = gnt;
        done      = 1'b0;
        rsp_ok    = 1'b0;
        rsp_data  = '0;

        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie, serve whoever was not served last
                    sel_d   = d_req && (!i_req || !last_d);
                    gnt_n   = sel_d;
                    cnt_n   = '0;
                    m_req_n = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                // An ack in the final allowed cycle still counts as success
                if (m_ack) begin
                    done     = 1'b1;
                    rsp_ok   = 1'b1;
                    rsp_data = m_rdata;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    done = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
                if (done) begin
                    state_n  = RESP;
                    m_req_n  = 1'b0;
                    last_d_n = gnt;
                    if (gnt) begin
                        d_ack_n   = rsp_ok;
                        d_err_n   = !rsp_ok;
                        d_rdata_n = rsp_data;
                    end else begin
                        i_ack_n   = rsp_ok;
                        i_err_n   = !rsp_ok;
                        i_rdata_n = rsp_data;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Memory command tracks the requester holding the grant while busy
        if (state_n == BUSY) begin
            m_addr_n  = sel_d ? d_addr : i_addr;
            m_we_n    = sel_d ? d_we : 1'b0;
            m_wdata_n = sel_d ? d_wdata : '0;
            m_wstrb_n = sel_d ? d_wstrb : '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            last_d  <= 1'b1;
            cnt     <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
            i_ack   <= 1'b0;
            i_err   <= 1'b0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            last_d  <= last_d_n;
            cnt     <= cnt_n;
            m_req   <= m_req_n;
            m_we    <= m_we_n;
            m_addr  <= m_addr_n;
            m_wdata <= m_wdata_n;
            m_wstrb <= m_wstrb_n;
            i_ack   <= i_ack_n;
            i_err   <= i_err_n;
            d_ack   <= d_ack_n;
            d_err   <= d_err_n;
            i_rdata <= i_rdata_n;
            d_rdata <= d_rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ack;
    logic [31:0] m_rdata;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          mb_busy, mb_resp, mb_who, mb_last_d, mb_ok;
    int          mb_waited;
    logic [31:0] mb_data;
    logic        e_mreq, e_we, e_iack, e_ierr, e_dack, e_derr;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
    logic [3:0]  e_wstrb;

    initial begin
        mb_busy = 0; mb_resp = 0; mb_who = 0; mb_last_d = 1; mb_waited = 0;
        e_mreq = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
        e_irdata = 0; e_drdata = 0;
        forever begin
            @(posedge clk);
            e_iack = 1'b0; e_ierr = 1'b0; e_dack = 1'b0; e_derr = 1'b0;
            if (rst) begin
                mb_busy = 0; mb_resp = 0; mb_last_d = 1;
                e_irdata = '0; e_drdata = '0;
            end else if (mb_resp) begin
                mb_resp = 0;
            end else if (mb_busy) begin
                if (m_ack || mb_waited == TIMEOUT - 1) begin
                    mb_ok   = m_ack;
                    mb_data = m_ack ? m_rdata : 32'h0;
                    if (mb_who) begin
                        e_dack = mb_ok; e_derr = !mb_ok; e_drdata = mb_data;
                    end else begin
                        e_iack = mb_ok; e_ierr = !mb_ok; e_irdata = mb_data;
                    end
                    mb_last_d = mb_who;
                    mb_busy   = 0;
                    mb_resp   = 1;
                end else begin
                    mb_waited++;
                end
            end else if (i_req || d_req) begin
                mb_who    = (i_req && d_req) ? !mb_last_d : d_req;
                mb_busy   = 1;
                mb_waited = 0;
                e_addr    = mb_who ? d_addr : i_addr;
                e_we      = mb_who ? d_we : 1'b0;
                e_wstrb   = mb_who ? d_wstrb : 4'h0;
                e_wdata   = d_wdata;
            end
            e_mreq = mb_busy;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("m_req",   32'(m_req),  32'(e_mreq));
            check("i_ack",   32'(i_ack),  32'(e_iack));
            check("i_err",   32'(i_err),  32'(e_ierr));
            check("d_ack",   32'(d_ack),  32'(e_dack));
            check("d_err",   32'(d_err),  32'(e_derr));
            check("i_rdata", i_rdata,     e_irdata);
            check("d_rdata", d_rdata,     e_drdata);
            if (e_mreq) begin
                check("m_addr",  m_addr,       e_addr);
                check("m_we",    32'(m_we),    32'(e_we));
                check("m_wstrb", 32'(m_wstrb), 32'(e_wstrb));
                if (mb_who) check("m_wdata", m_wdata, e_wdata);
            end
        end
    end

    // ---------------- stimulus agents ----------------
    int          f_rate, d_rate;
    int          mem_lat_fix;     // -1 random, 0 never ack, N ack in Nth m_req cycle
    int          mem_lat, mem_seen;
    bit          stray_en, mem_rd_fixed;
    logic [31:0] mem_rd_val;

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 60) return int'($urandom_range(1, 4));
        if (r < 75) return int'($urandom_range(5, 13));
        if (r < 90) return int'($urandom_range(14, 16));
        return 0;
    endfunction

    task automatic agents();
        if (m_req) begin
            if (mem_seen == 0) mem_lat = (mem_lat_fix >= 0) ? mem_lat_fix : pick_lat();
            mem_seen++;
            m_ack = (mem_lat != 0) && (mem_seen == mem_lat);
        end else begin
            mem_seen = 0;
            m_ack = stray_en && ($urandom_range(0, 5) == 0);
        end
        m_rdata = mem_rd_fixed ? mem_rd_val : $urandom;
        if (i_ack || i_err) i_req = 1'b0;
        if (!i_req && (int'($urandom_range(1, 100)) <= f_rate)) begin
            i_req  = 1'b1;
            i_addr = {4'h1, 28'($urandom)};
        end
        if (d_ack || d_err) d_req = 1'b0;
        if (!d_req && (int'($urandom_range(1, 100)) <= d_rate)) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = {4'h2, 28'($urandom)};
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        agents();
    endtask

    task automatic wait_resp(input string name, input int max, output int mreq_n);
        mreq_n = 0;
        for (int k = 0; k < max; k++) begin
            tick();
            @(negedge clk);
            if (m_req) mreq_n++;
            if (i_ack || i_err || d_ack || d_err) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: no response within %0d cycles", name, max);
    endtask

    task automatic drain();
        int left;
        f_rate = 0; d_rate = 0;
        left = 200;
        while ((i_req || d_req || m_req) && left > 0) begin
            tick();
            left--;
        end
        if (left == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: requests still pending");
        end
    endtask

    initial begin
        int n, cnt;
        logic prev;
        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_wstrb = 0; m_ack = 0; m_rdata = 0;
        f_rate = 0; d_rate = 0; mem_lat_fix = 2; mem_lat = 0; mem_seen = 0;
        stray_en = 0; mem_rd_fixed = 1; mem_rd_val = 32'h0000_0013;

        // Reset state
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_m_req",   32'(m_req), 32'h0);
        check("rst_i_rdata", i_rdata,    32'h0);
        check("rst_i_ack",   32'(i_ack), 32'h0);

        // Single fetch, memory acks one cycle after m_req rises
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h0;
        tick(); @(negedge clk);
        check("f1_m_req",  32'(m_req), 32'h1);
        check("f1_m_addr", m_addr,     32'h0);
        check("f1_m_we",   32'(m_we),  32'h0);
        tick(); @(negedge clk);
        check("f1_early_ack", 32'(i_ack), 32'h0);
        tick(); @(negedge clk);
        check("f1_i_ack",   32'(i_ack), 32'h1);
        check("f1_i_rdata", i_rdata,    32'h0000_0013);

        // Simultaneous fetch and store: fetch first, then store, then tie to fetch
        rst = 1'b1; tick(); rst = 1'b0;
        mem_lat_fix = 1; mem_rd_val = 32'h0;
        i_req = 1; i_addr = 32'h40;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h34; d_wstrb = 4'hF;
        tick(); @(negedge clk);
        check("tie_first_addr", m_addr,    32'h40);
        check("tie_first_we",   32'(m_we), 32'h0);
        tick(); @(negedge clk);
        check("tie_i_ack", 32'(i_ack), 32'h1);
        tick(); tick(); @(negedge clk);
        check("st_m_we",    32'(m_we),    32'h1);
        check("st_m_addr",  m_addr,       32'h100);
        check("st_m_wdata", m_wdata,      32'h34);
        check("st_m_wstrb", 32'(m_wstrb), 32'hF);
        tick(); @(negedge clk);
        check("st_d_ack", 32'(d_ack), 32'h1);
        i_req = 1; i_addr = 32'h80;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        tick(); tick(); @(negedge clk);
        check("tie2_addr", m_addr, 32'h80);
        drain();

        // Both requesters saturated: grants alternate F,D,F,D,F,D
        rst = 1'b1; tick(); rst = 1'b0;
        mem_lat_fix = 2; f_rate = 100; d_rate = 100;
        n = 0; prev = 1'b0;
        for (int k = 0; k < 200 && n < 6; k++) begin
            tick(); @(negedge clk);
            if (m_req && !prev) begin
                check("alternate", 32'(m_addr[31:28]), (n % 2 == 0) ? 32'h1 : 32'h2);
                n++;
            end
            prev = m_req;
        end
        if (n < 6) begin
            n_checks++; n_fail++;
            $display("FAIL alternate: only %0d grants seen", n);
        end
        drain();

        // Timeout: a good load first so d_rdata is nonzero, then a load never acked
        rst = 1'b1; tick(); rst = 1'b0;
        mem_lat_fix = 1; mem_rd_val = 32'hDEAD_BEEF;
        d_req = 1; d_we = 0; d_addr = 32'h2000_0010;
        wait_resp("load_ok", 20, cnt);
        check("load_d_rdata", d_rdata, 32'hDEAD_BEEF);
        mem_lat_fix = 0;
        d_req = 1; d_we = 0; d_addr = 32'h2000_0014;
        wait_resp("timeout", 40, cnt);
        check("to_mreq_cycles", 32'(cnt),   32'd15);
        check("to_d_err",       32'(d_err), 32'h1);
        check("to_d_ack",       32'(d_ack), 32'h0);
        check("to_d_rdata",     d_rdata,    32'h0);
        tick(); @(negedge clk);
        check("to_idle_m_req", 32'(m_req), 32'h0);
        check("to_err_pulse",  32'(d_err), 32'h0);

        // Ack in the last allowed cycle wins over the timeout
        mem_lat_fix = 15; mem_rd_val = 32'hCAFE_0001;
        d_req = 1; d_we = 0; d_addr = 32'h2000_0018;
        wait_resp("late_ack", 40, cnt);
        check("late_mreq_cycles", 32'(cnt),   32'd15);
        check("late_d_ack",       32'(d_ack), 32'h1);
        check("late_d_err",       32'(d_err), 32'h0);
        check("late_d_rdata",     d_rdata,    32'hCAFE_0001);

        // Reset in the middle of a data access
        rst = 1'b1; tick(); rst = 1'b0;
        mem_lat_fix = 1;
        i_req = 1; i_addr = 32'h1000_0000;
        wait_resp("pre_fetch", 20, cnt);
        mem_lat_fix = 0;
        i_req = 1; i_addr = 32'h1000_0004;
        d_req = 1; d_we = 0; d_addr = 32'h2000_0008;
        tick(); tick(); @(negedge clk);
        check("rb_grant_data", m_addr, 32'h2000_0008);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        check("rb_m_req", 32'(m_req), 32'h0);
        mem_lat_fix = 1;
        tick(); @(negedge clk);
        check("rb_tie_fetch", m_addr, 32'h1000_0004);
        wait_resp("rb_resp", 20, cnt);
        check("rb_i_ack", 32'(i_ack), 32'h1);
        check("rb_d_ack", 32'(d_ack), 32'h0);
        check("rb_d_err", 32'(d_err), 32'h0);
        drain();

        // Randomized traffic with stray acks and occasional resets
        stray_en = 1; mem_rd_fixed = 0; mem_lat_fix = -1;
        for (int k = 0; k < 4000; k++) begin
            if (k % 500 == 0) begin
                f_rate = int'($urandom_range(0, 100));
                d_rate = int'($urandom_range(0, 100));
            end
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        stray_en = 0;
        drain();
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
